avalon_scratch_responder: RTL and testbench

Avalon-MM slave responder fronting an on-chip 32-bit scratchpad RAM. It serves the SDRAM-facing master port of the pooling accelerators (max/avg controllers) so that layer buffers can live on-chip. It completes each read or write after a programmable number of waitrequest stall cycles. It also keeps access and error counters for bring-up and debug.

---
 rtl/avalon_scratch_responder.sv | 124 ++++++++++++
 tb/tb_avalon_scratch_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_scratch_responder.sv
// Avalon-MM slave in front of an on-chip 32-bit scratchpad RAM.
// Every transfer stalls for WAIT_CYCLES, then acks. Access and error counters support bring-up.
module avalon_scratch_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    input  logic        err_clear,
    output logic        err_flag,
    output logic [15:0] err_count,
    output logic [31:0] read_count,
    output logic [31:0] write_count
);

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_wr;
    logic                    lat_err;
    logic                    lat_ok;
    logic [ADDR_WIDTH-1:0]   lat_word;
    logic [31:0]             lat_data;

    logic                    req;
    logic [31:0]             offset;
    logic                    addr_ok;
    logic                    final_stall;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Handshake: a transfer completes in the cycle where req=1 and waitrequest=0 (ACK state only).
    assign req               = slave_read | slave_write;
    assign slave_waitrequest = req & (state != ACK);

    assign offset      = slave_address - BASE_ADDR;
    assign addr_ok     = (offset[1:0] == 2'b00) && !(|offset[31:ADDR_WIDTH+2]);
    assign final_stall = (state == STALL) && req && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_wr      <= 1'b0;
            lat_err     <= 1'b0;
            lat_ok      <= 1'b0;
            lat_word    <= '0;
            lat_data    <= 32'h0;
            err_flag    <= 1'b0;
            err_count   <= 16'h0;
            read_count  <= 32'h0;
            write_count <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_wr   <= slave_write;
                        lat_ok   <= addr_ok;
                        lat_err  <= !addr_ok || (slave_read && slave_write);
                        lat_word <= offset[ADDR_WIDTH+1:2];
                        lat_data <= slave_writedata;
                        cnt      <= 4'd0;
                        state    <= STALL;
                    end
                end
                STALL: begin
                    // A request withdrawn mid-stall abandons the transfer with no side effects.
                    if (!req)
                        state <= IDLE;
                    else if (cnt == LAST_CNT)
                        state <= ACK;
                    else
                        cnt <= cnt + 4'd1;
                end
                ACK: begin
                    state <= IDLE;
                    if (lat_err) begin
                        err_flag <= 1'b1;
                        if (err_count != 16'hFFFF)
                            err_count <= err_count + 16'd1;
                    end else if (lat_wr) begin
                        if (write_count != 32'hFFFF_FFFF)
                            write_count <= write_count + 32'd1;
                    end else begin
                        if (read_count != 32'hFFFF_FFFF)
                            read_count <= read_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides an error recorded in the same cycle.
            if (err_clear) begin
                err_flag  <= 1'b0;
                err_count <= 16'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (state == ACK) && lat_wr && lat_ok)
            mem[lat_word] <= lat_data;
    end

    // Loaded on the last stall cycle so the word appears exactly in ACK, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset)
            slave_readdata <= 32'h0;
        else if (final_stall && !lat_wr && !lat_err)
            slave_readdata <= mem[lat_word];
        else
            slave_readdata <= 32'h0;
    end

endmodule

// File: tb/tb_avalon_scratch_responder.sv
// Bench for avalon_scratch_responder: a WAIT_CYCLES=1 and a WAIT_CYCLES=4 instance,
// directed transfers with expected read data queued and checked by a completion monitor.
module tb_avalon_scratch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        err_clear;
    logic        sel;

    logic [31:0] a_rdata, b_rdata, m_rdata;
    logic        a_wait, b_wait, m_wait;
    logic        a_ef, b_ef, m_ef;
    logic [15:0] a_ec, b_ec, m_ec;
    logic [31:0] a_rc, b_rc, m_rc;
    logic [31:0] a_wc, b_wc, m_wc;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    avalon_scratch_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
        .clk(clk), .reset(reset),
        .slave_address(address), .slave_read(rd & !sel), .slave_readdata(a_rdata),
        .slave_write(wr & !sel), .slave_writedata(wdata), .slave_waitrequest(a_wait),
        .err_clear(err_clear & !sel), .err_flag(a_ef), .err_count(a_ec),
        .read_count(a_rc), .write_count(a_wc)
    );

    avalon_scratch_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(4), .BASE_ADDR(32'h0)) u_w4 (
        .clk(clk), .reset(reset),
        .slave_address(address), .slave_read(rd & sel), .slave_readdata(b_rdata),
        .slave_write(wr & sel), .slave_writedata(wdata), .slave_waitrequest(b_wait),
        .err_clear(err_clear & sel), .err_flag(b_ef), .err_count(b_ec),
        .read_count(b_rc), .write_count(b_wc)
    );

    assign m_rdata = sel ? b_rdata : a_rdata;
    assign m_wait  = sel ? b_wait  : a_wait;
    assign m_ef    = sel ? b_ef    : a_ef;
    assign m_ec    = sel ? b_ec    : a_ec;
    assign m_rc    = sel ? b_rc    : a_rc;
    assign m_wc    = sel ? b_wc    : a_wc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: completions pop the queue, every other cycle must show zero read data.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if ((rd | wr) && !m_wait) begin
                if (exp_q.size() == 0) begin
                    check("unexpected completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("readdata", m_rdata, e);
                end
            end else begin
                check("readdata idle", m_rdata, 32'h0);
            end
        end
    end

    // Called just after a rising edge while the DUT is in IDLE.
    task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int exp_lat, input bit hold);
        int  lat;
        bit  done;
        address = a;
        rd      = r;
        wr      = w;
        wdata   = d;
        exp_q.push_back(exp_rd);
        lat  = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!m_wait) done = 1;
            else lat++;
        end
        if (!done) check("completion timeout", 32'd0, 32'd1);
        else check("latency", lat, exp_lat);
        @(posedge clk); #1;
        if (!hold) begin
            rd = 1'b0;
            wr = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        sel       = 1'b0;
        reset     = 1'b1;
        rd        = 1'b1;
        wr        = 1'b0;
        address   = 32'h0;
        wdata     = 32'h0;
        err_clear = 1'b0;

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset waitrequest", m_wait, 32'd1);
        check("reset read_count", m_rc, 32'd0);
        check("reset write_count", m_wc, 32'd0);
        check("reset err_count", m_ec, 32'd0);
        check("reset err_flag", m_ef, 32'd0);
        tick();
        reset = 1'b0;
        rd    = 1'b0;
        @(negedge clk);
        check("readdata after reset", m_rdata, 32'h0);
        check("waitrequest no req", m_wait, 32'd0);
        tick();

        xfer(0, 1, 32'h10, 32'hCAFE0001, 32'h0, 2, 0);
        check("write_count single", m_wc, 32'd1);
        xfer(1, 0, 32'h10, 32'h0, 32'hCAFE0001, 2, 0);
        check("read_count single", m_rc, 32'd1);

        xfer(0, 1, 32'h0, 32'd5, 32'h0, 2, 1);
        xfer(0, 1, 32'h4, 32'd9, 32'h0, 2, 1);
        xfer(0, 1, 32'h8, 32'd2, 32'h0, 2, 1);
        xfer(0, 1, 32'hC, 32'd7, 32'h0, 2, 1);
        xfer(1, 0, 32'h0, 32'h0, 32'd5, 2, 1);
        xfer(1, 0, 32'h4, 32'h0, 32'd9, 2, 1);
        xfer(1, 0, 32'h8, 32'h0, 32'd2, 2, 1);
        xfer(1, 0, 32'hC, 32'h0, 32'd7, 2, 0);
        check("burst write_count", m_wc, 32'd5);
        check("burst read_count", m_rc, 32'd5);

        xfer(1, 0, 32'h12, 32'h0, 32'h0, 2, 0);
        check("misaligned err_flag", m_ef, 32'd1);
        check("misaligned err_count", m_ec, 32'd1);
        check("misaligned read_count", m_rc, 32'd5);
        xfer(0, 1, 32'h1000, 32'hDEAD, 32'h0, 2, 0);
        check("range err_count", m_ec, 32'd2);
        check("range write_count", m_wc, 32'd5);
        xfer(1, 0, 32'h0, 32'h0, 32'd5, 2, 0);

        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clear err_flag", m_ef, 32'd0);
        check("clear err_count", m_ec, 32'd0);

        err_clear = 1'b1;
        xfer(1, 0, 32'h2, 32'h0, 32'h0, 2, 0);
        err_clear = 1'b0;
        check("clear wins err_flag", m_ef, 32'd0);
        check("clear wins err_count", m_ec, 32'd0);
        check("clear wins read_count", m_rc, 32'd6);

        xfer(1, 1, 32'h0, 32'hAA, 32'h0, 2, 0);
        check("rdwr err_count", m_ec, 32'd1);
        check("rdwr err_flag", m_ef, 32'd1);
        check("rdwr write_count", m_wc, 32'd5);
        xfer(1, 0, 32'h0, 32'h0, 32'hAA, 2, 0);
        check("rdwr readback count", m_rc, 32'd7);

        sel = 1'b1;
        tick();
        xfer(0, 1, 32'h8, 32'h11, 32'h0, 5, 0);
        check("w4 write_count", m_wc, 32'd1);

        address = 32'h8;
        wdata   = 32'h77;
        wr      = 1'b1;
        tick();
        tick();
        wr = 1'b0;
        tick();
        tick();
        check("abort write_count", m_wc, 32'd1);
        check("abort read_count", m_rc, 32'd0);
        check("abort err_count", m_ec, 32'd0);
        xfer(1, 0, 32'h8, 32'h0, 32'h11, 5, 0);
        check("abort read_count after", m_rc, 32'd1);

        address = 32'h8;
        wdata   = 32'h99;
        wr      = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        wr    = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post reset waitrequest", m_wait, 32'd0);
        check("post reset write_count", m_wc, 32'd0);
        check("post reset read_count", m_rc, 32'd0);
        tick();
        xfer(1, 0, 32'h8, 32'h0, 32'h11, 5, 0);
        check("post reset read_count after", m_rc, 32'd1);

        tick();
        check("queue drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
